// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time write-back bypass, EX-time operand
// forwarding, load-use hazard detection and a saturating inserted-bubble counter.
module id_ex_stage (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_alu_op,
    input  logic        id_b_imm,
    input  logic        id_rf_we,
    input  logic        id_is_load,
    input  logic        id_mem_we,
    input  logic [4:0]  mem_rd,
    input  logic        mem_rf_we,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_rf_we,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_alu_op,
    output logic [4:0]  ex_rd,
    output logic        ex_rf_we,
    output logic        ex_is_load,
    output logic        ex_mem_we,
    output logic [31:0] ex_store_data,
    output logic        id_stall,
    output logic [15:0] bubble_cnt
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, alu_op_q, alu_op_d;
    logic [31:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
    logic        rf_we_q, rf_we_d, is_load_q, is_load_d, mem_we_q, mem_we_d;
    logic        b_imm_q, b_imm_d;
    logic [15:0] cnt_q, cnt_d;

    logic        hazard, capture;
    logic [31:0] fwd_rs1, fwd_rs2;

    assign hazard   = valid_q && is_load_q && (rd_q != '0) && id_valid &&
                      ((rd_q == id_rs1) || (rd_q == id_rs2));
    assign id_stall = hazard && !flush;
    assign capture  = id_valid && !hazard && !flush;

    always_comb begin
        // Bubble by default: every field zero so bubbles are deterministic.
        valid_d   = 1'b0;
        pc_d      = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        alu_op_d  = '0;
        rs1_val_d = '0;
        rs2_val_d = '0;
        imm_d     = '0;
        rf_we_d   = 1'b0;
        is_load_d = 1'b0;
        mem_we_d  = 1'b0;
        b_imm_d   = 1'b0;
        cnt_d     = cnt_q;
        if (capture) begin
            valid_d   = 1'b1;
            pc_d      = id_pc;
            rs1_d     = id_rs1;
            rs2_d     = id_rs2;
            rd_d      = id_rd;
            alu_op_d  = id_alu_op;
            rs1_val_d = (wb_rf_we && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
            rs2_val_d = (wb_rf_we && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
            imm_d     = id_imm;
            rf_we_d   = id_rf_we;
            is_load_d = id_is_load;
            mem_we_d  = id_mem_we;
            b_imm_d   = id_b_imm;
        end else if (id_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            alu_op_q  <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            rf_we_q   <= 1'b0;
            is_load_q <= 1'b0;
            mem_we_q  <= 1'b0;
            b_imm_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            alu_op_q  <= alu_op_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            rf_we_q   <= rf_we_d;
            is_load_q <= is_load_d;
            mem_we_q  <= mem_we_d;
            b_imm_q   <= b_imm_d;
            cnt_q     <= cnt_d;
        end
    end

    // MEM result wins over WB data; x0 never forwards.
    always_comb begin
        fwd_rs1 = rs1_val_q;
        if (rs1_q != '0) begin
            if (mem_rf_we && (mem_rd == rs1_q))     fwd_rs1 = mem_result;
            else if (wb_rf_we && (wb_rd == rs1_q))  fwd_rs1 = wb_data;
        end
        fwd_rs2 = rs2_val_q;
        if (rs2_q != '0) begin
            if (mem_rf_we && (mem_rd == rs2_q))     fwd_rs2 = mem_result;
            else if (wb_rf_we && (wb_rd == rs2_q))  fwd_rs2 = wb_data;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_a          = fwd_rs1;
    assign ex_b          = b_imm_q ? imm_q : fwd_rs2;
    assign ex_imm        = imm_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_rd         = rd_q;
    assign ex_rf_we      = rf_we_q;
    assign ex_is_load    = is_load_q;
    assign ex_mem_we     = mem_we_q;
    assign ex_store_data = fwd_rs2;
    assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a transaction-level
// model of the EX register contents and the bubble counter.
module tb_id_ex_stage;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        id_valid, id_b_imm, id_rf_we, id_is_load, id_mem_we;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_rf_we, wb_rf_we, flush;
    logic [31:0] mem_result, wb_data;
    logic        ex_valid, ex_rf_we, ex_is_load, ex_mem_we, id_stall;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm, ex_store_data;
    logic [4:0]  ex_alu_op, ex_rd;
    logic [15:0] bubble_cnt;

    always #5 cpu_clk = ~cpu_clk;

    id_ex_stage dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_b_imm(id_b_imm), .id_rf_we(id_rf_we),
        .id_is_load(id_is_load), .id_mem_we(id_mem_we),
        .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .ex_mem_we(ex_mem_we), .ex_store_data(ex_store_data),
        .id_stall(id_stall), .bubble_cnt(bubble_cnt)
    );

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction held in EX, as a record.
    typedef struct {
        bit          valid;
        logic [31:0] pc, v1, v2, imm;
        logic [4:0]  rs1, rs2, rd, op;
        bit          rfwe, ld, mwe, bimm;
    } ex_t;

    ex_t         m;
    int unsigned m_cnt;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        if (r == 0) return v;
        if (mem_rf_we && mem_rd == r) return mem_result;
        if (wb_rf_we && wb_rd == r) return wb_data;
        return v;
    endfunction

    function automatic bit m_hazard();
        return m.valid && m.ld && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    always @(posedge cpu_clk) begin
        ex_t n;
        bit  hz;
        n  = '{default: 0};
        hz = m_hazard();
        if (!cpu_rst_n) begin
            m_cnt = 0;
        end else if (id_valid && !hz && !flush) begin
            n.valid = 1; n.pc = id_pc; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
            n.op = id_alu_op; n.imm = id_imm; n.rfwe = id_rf_we; n.ld = id_is_load;
            n.mwe = id_mem_we; n.bimm = id_b_imm;
            n.v1 = (wb_rf_we && wb_rd != 0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
            n.v2 = (wb_rf_we && wb_rd != 0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
        end else if (id_valid) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
        m = n;
    end

    always @(negedge cpu_clk) begin
        #2;
        if (check_en) begin
            logic [31:0] f2;
            f2 = fwd(m.rs2, m.v2);
            chk("ex_valid", ex_valid, m.valid);
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_a", ex_a, fwd(m.rs1, m.v1));
            chk("ex_b", ex_b, m.bimm ? m.imm : f2);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_alu_op", ex_alu_op, m.op);
            chk("ex_rd", ex_rd, m.rd);
            chk("ex_ctl", {ex_rf_we, ex_is_load, ex_mem_we}, {m.rfwe, m.ld, m.mwe});
            chk("ex_store_data", ex_store_data, f2);
            chk("id_stall", id_stall, m_hazard() && !flush);
            chk("bubble_cnt", bubble_cnt, m_cnt);
        end
    end

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0; id_b_imm = 0;
        id_rf_we = 0; id_is_load = 0; id_mem_we = 0;
        mem_rd = 0; mem_rf_we = 0; mem_result = 0;
        wb_rd = 0; wb_rf_we = 0; wb_data = 0; flush = 0;
    endtask

    initial begin
        idle();
        cpu_rst_n = 0;
        @(negedge cpu_clk); id_valid = 1; flush = 1;
        @(posedge cpu_clk); #1;
        check_en = 1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_a", ex_a, 0);
        chk("rst_cnt", bubble_cnt, 0);

        // Basic capture
        @(negedge cpu_clk); idle(); cpu_rst_n = 1;
        @(negedge cpu_clk);
        id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_rs1_data = 5; id_rs2 = 2;
        id_rs2_data = 7; id_alu_op = 5'b00010; id_rd = 3; id_rf_we = 1;
        @(posedge cpu_clk); #1;
        chk("basic_valid", ex_valid, 1);
        chk("basic_pc", ex_pc, 32'h100);
        chk("basic_a", ex_a, 5);
        chk("basic_b", ex_b, 7);
        chk("basic_op", ex_alu_op, 5'b00010);

        // Forwarding priority
        @(negedge cpu_clk); idle();
        id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h11; id_alu_op = 1;
        @(negedge cpu_clk); idle();
        mem_rd = 3; mem_result = 32'hAA; mem_rf_we = 1; wb_rd = 3; wb_data = 32'hBB; wb_rf_we = 1;
        #1 chk("fwd_mem", ex_a, 32'hAA);
        mem_rf_we = 0;
        #2 chk("fwd_wb", ex_a, 32'hBB);
        mem_rf_we = 1; mem_rd = 0; wb_rd = 0;
        #1 chk("fwd_x0", ex_a, 32'h11);

        // Load-use
        @(negedge cpu_clk); idle();
        id_valid = 1; id_is_load = 1; id_rd = 4; id_rf_we = 1; id_pc = 32'h200;
        @(negedge cpu_clk); idle();
        id_valid = 1; id_rs2 = 4; id_rs2_data = 9; id_pc = 32'h204; id_rd = 6; id_rf_we = 1;
        #1 chk("lu_stall", id_stall, 1);
        @(posedge cpu_clk); #1;
        chk("lu_bubble", ex_valid, 0);
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_stall_clr", id_stall, 0);
        @(posedge cpu_clk); #1;
        chk("lu_capt", ex_valid, 1);
        chk("lu_pc", ex_pc, 32'h204);
        chk("lu_cnt2", bubble_cnt, 1);

        // Flush with hazard
        @(negedge cpu_clk); idle();
        id_valid = 1; id_is_load = 1; id_rd = 4; id_rf_we = 1;
        @(negedge cpu_clk); idle();
        id_valid = 1; id_rs1 = 4; flush = 1;
        #1 chk("fl_stall", id_stall, 0);
        @(posedge cpu_clk); #1;
        chk("fl_bubble", ex_valid, 0);
        chk("fl_cnt", bubble_cnt, 2);

        // Capture-time bypass
        @(negedge cpu_clk); idle();
        id_valid = 1; id_rs1 = 5; id_rs1_data = 0; wb_rd = 5; wb_data = 32'h1234; wb_rf_we = 1;
        @(negedge cpu_clk); idle();
        #1 chk("bypass_a", ex_a, 32'h1234);

        // Randomized traffic, small register range to provoke hazards
        repeat (3000) begin
            @(negedge cpu_clk);
            cpu_rst_n   = ($urandom_range(63) != 0);
            id_valid    = ($urandom_range(3) != 0);
            id_pc       = $urandom;
            id_rs1      = 5'($urandom_range(7));
            id_rs2      = 5'($urandom_range(7));
            id_rd       = 5'($urandom_range(7));
            id_rs1_data = $urandom;
            id_rs2_data = $urandom;
            id_imm      = $urandom;
            id_alu_op   = 5'($urandom);
            id_b_imm    = 1'($urandom);
            id_rf_we    = 1'($urandom);
            id_is_load  = ($urandom_range(2) == 0);
            id_mem_we   = 1'($urandom);
            mem_rd      = 5'($urandom_range(7));
            mem_rf_we   = 1'($urandom);
            mem_result  = $urandom;
            wb_rd       = 5'($urandom_range(7));
            wb_rf_we    = 1'($urandom);
            wb_data     = $urandom;
            flush       = ($urandom_range(7) == 0);
        end

        // Saturation then reset
        @(negedge cpu_clk); idle(); cpu_rst_n = 0;
        @(negedge cpu_clk); cpu_rst_n = 1; id_valid = 1; flush = 1;
        repeat (65540) @(posedge cpu_clk);
        #1 chk("sat_cnt", bubble_cnt, 16'hFFFF);
        @(negedge cpu_clk); flush = 0; cpu_rst_n = 0; id_valid = 1; id_pc = 32'h300;
        @(posedge cpu_clk); #1;
        chk("sat_rst_valid", ex_valid, 0);
        chk("sat_rst_cnt", bubble_cnt, 0);
        @(negedge cpu_clk); idle(); cpu_rst_n = 1;
        @(negedge cpu_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
